md_unit: RTL
============

# md_unit

Multiply/divide unit in the EX stage of the five-stage pipeline, beside the ALU and driven by the same per-instruction decode. It executes mult/multu/div/divu over a fixed multi-cycle latency, holds the HI/LO architectural registers, services mthi/mtlo writes, and exposes a busy indication that the hazard unit uses to stall mfhi/mflo and further MD instructions.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu
- DIV_CYCLES, 10, cycles Busy stays high for div/divu
- clk  in  1  pipeline clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- Start  in  1  EX-stage MD instruction valid this cycle
- MDOp  in  3  operation: MD_mult, MD_multu, MD_div, MD_divu, MD_mthi, MD_mtlo (MD_none otherwise)
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- Busy  out  1  registered; high while an operation is in flight
- HI  out  32  registered HI value
- LO  out  32  registered LO value

## Operation
- Reset (reset=0): Busy=0, HI=0, LO=0, counter=0, pending regs=0; takes effect asynchronously.
- Accept: on rising edge with Start=1, Busy=0, MDOp in {mult,multu,div,divu}: compute result, latch into pendHI/pendLO, load counter with MULT_CYCLES or DIV_CYCLES, set Busy=1.
- Count: each edge with Busy=1, counter decrements; on edge where counter==1, HI<=pendHI, LO<=pendLO, Busy<=0, counter<=0.
- mthi/mtlo: on edge with Start=1, Busy=0: HI<=A or LO<=A respectively; Busy stays 0.
- Start while Busy=1: ignored entirely (hazard unit guarantees stall; unit must not corrupt state).
- MDOp=MD_none or Start=0: no state change except counting.
- Arithmetic: mult = signed 32x32->64, multu unsigned; {HI,LO}=product. div: LO=quotient truncated toward zero, HI=remainder with sign of dividend; divu unsigned.
- Corner cases: B=0 on div/divu -> pendHI/pendLO = current HI/LO (registers retained), full DIV_CYCLES latency still applied. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI/LO outputs never show pending values before commit.

## Timing
- Start accepted at edge T0; Busy=1 for exactly N cycles (visible after T0 through edge T0+N); HI/LO new values and Busy=0 visible after edge T0+N.
- Back-to-back: a new Start accepted on edge T0+N+1 at earliest (first cycle Busy reads 0).
- mthi/mtlo latency 1 edge; mfhi in the next cycle reads the new value.
- Reset asserted mid-operation aborts it: no commit, HI/LO=0, Busy=0 immediately; first edge after release is idle.
- No combinational path from inputs to outputs.

## Structure
- MDOp encodings (MD_none, MD_mult, MD_multu, MD_div, MD_divu, MD_mthi, MD_mtlo) belong in the shared CPU_Param.v header alongside the ALU op codes, so the decoder and this unit use one definition.
- Single module; the counter/commit logic is small. Optional combinational sub-module md_calc (A, B, MDOp, HI, LO -> pendHI, pendLO) isolates arithmetic and div-by-zero handling.

## Test plan
- Reset then idle: HI=0, LO=0, Busy=0; reset asserted mid-div at cycle 4 -> Busy=0, HI/LO=0 immediately, no later commit.
- mult A=0xFFFFFFFF, B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu A=7,B=2 -> LO=3, HI=1.
- div B=0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> after 10 cycles HI=0x11, LO=0x22; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult while Busy from a prior div -> ignored; final HI/LO equal div result, Busy falls at div's cycle 10.
- mtlo A=0xDEADBEEF -> LO=0xDEADBEEF after one edge, Busy stays 0; Start mult on the edge Busy first reads 0 after a prior op -> accepted.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and latency defaults.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_none  = 3'd0,
        MD_mult  = 3'd1,
        MD_multu = 3'd2,
        MD_div   = 3'd3,
        MD_divu  = 3'd4,
        MD_mthi  = 3'd5,
        MD_mtlo  = 3'd6
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    function automatic int unsigned md_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic for md_unit: produces the pending HI/LO pair for a
// mult/multu/div/divu, falling back to the current HI/LO for divide-by-zero.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic [31:0] pendHI,
    output logic [31:0] pendLO
);

    md_op_e             op;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic signed [31:0] squot;
    logic signed [31:0] srem;

    assign op    = md_op_e'(MDOp);
    assign sa    = {{32{A[31]}}, A};
    assign sb    = {{32{B[31]}}, B};
    assign sprod = sa * sb;
    assign uprod = {32'd0, A} * {32'd0, B};

    // Signed quotient/remainder; the only overflowing case is pinned explicitly
    always_comb begin
        squot = '0;
        srem  = '0;
        if (A == 32'h8000_0000 && B == '1) begin
            squot = $signed(A);
            srem  = '0;
        end else if (B != '0) begin
            squot = $signed(A) / $signed(B);
            srem  = $signed(A) % $signed(B);
        end
    end

    // Select the result pair by operation; divide-by-zero keeps HI/LO as they are
    always_comb begin
        pendHI = HI;
        pendLO = LO;
        case (op)
            MD_mult:  {pendHI, pendLO} = sprod;
            MD_multu: {pendHI, pendLO} = uprod;
            MD_div: begin
                if (B != '0) begin
                    pendHI = srem;
                    pendLO = squot;
                end
            end
            MD_divu: begin
                if (B != '0) begin
                    pendHI = A % B;
                    pendLO = A / B;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div, HI/LO registers,
// mthi/mtlo writes and a registered Busy for the hazard unit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_W = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);

    md_op_e             op;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pendHI;
    logic [31:0]        pendLO;
    logic [31:0]        calcHI;
    logic [31:0]        calcLO;

    assign op = md_op_e'(MDOp);

    md_calc u_calc (
        .A      (A),
        .B      (B),
        .MDOp   (MDOp),
        .HI     (HI),
        .LO     (LO),
        .pendHI (calcHI),
        .pendLO (calcLO)
    );

    // Accept new ops when idle, count down while busy, commit pending result on the last count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Busy   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            cnt    <= '0;
            pendHI <= '0;
            pendLO <= '0;
        end else if (Busy) begin
            if (cnt == CNT_W'(1)) begin
                HI   <= pendHI;
                LO   <= pendLO;
                Busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (Start) begin
            case (op)
                MD_mult, MD_multu: begin
                    pendHI <= calcHI;
                    pendLO <= calcLO;
                    cnt    <= CNT_W'(MULT_CYCLES);
                    Busy   <= 1'b1;
                end
                MD_div, MD_divu: begin
                    pendHI <= calcHI;
                    pendLO <= calcLO;
                    cnt    <= CNT_W'(DIV_CYCLES);
                    Busy   <= 1'b1;
                end
                MD_mthi: HI <= A;
                MD_mtlo: LO <= A;
                default: ;
            endcase
        end
    end

endmodule
